// File: rtl/online_mult_seq_if.sv
// Handshake bundle for the online multiplier sequencer: operation control
// plus the serial input-digit and output-digit valid/ready pairs.
interface online_mult_seq_if;
  logic start;
  logic busy;
  logic done;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport slave (
    input  start, in_valid, out_ready,
    output busy, done, in_ready, out_valid
  );

  modport master (
    output start, in_valid, out_ready,
    input  busy, done, in_ready, out_valid
  );
endinterface

// File: rtl/online_mult_seq.sv
// Iteration sequencer for a radix-2 MSD-first online multiplier: counts the
// N+DELTA iterations, splits warm-up/steady/flush and pairs the handshakes.
module online_mult_seq #(
  parameter int N     = 8,
  parameter int DELTA = 3,
  parameter int CW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  online_mult_seq_if.slave    hs,
  output logic                step_en,
  output logic                clr_w,
  output logic [CW-1:0]       app_idx,
  output logic [CW-1:0]       k,
  output logic                in_phase,
  output logic                out_phase,
  output logic                last
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] N_C     = CW'(N);
  localparam logic [CW-1:0] DELTA_C = CW'(DELTA);
  localparam logic [CW-1:0] LAST_C  = CW'(N + DELTA - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic          in_ready_s;
  logic          out_valid_s;
  logic          done_s;

  // Phase decodes depend only on k, so they read sensibly even in IDLE.
  assign in_phase  = (k_q < N_C);
  assign out_phase = (k_q >= DELTA_C);
  assign last      = (k_q == LAST_C);
  assign k         = k_q;
  assign app_idx   = in_phase ? k_q : {CW{1'b0}};

  assign hs.busy      = (state_q != S_IDLE);
  assign hs.done      = done_s;
  assign hs.in_ready  = in_ready_s;
  assign hs.out_valid = out_valid_s;

  // State and iteration counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state and handshake decode; a stall on either side stalls both.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    step_en     = 1'b0;
    clr_w       = 1'b0;
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    done_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        clr_w = hs.start;
        if (hs.start) begin
          state_d = S_RUN;
          k_d     = {CW{1'b0}};
        end else begin
          state_d = S_IDLE;
          k_d     = k_q;
        end
      end
      S_RUN: begin
        step_en     = (!in_phase || hs.in_valid) && (!out_phase || hs.out_ready);
        in_ready_s  = in_phase && (!out_phase || hs.out_ready);
        out_valid_s = out_phase && (!in_phase || hs.in_valid);
        if (step_en && last) begin
          state_d = S_DONE;
          k_d     = {CW{1'b0}};
        end else if (step_en) begin
          state_d = S_RUN;
          k_d     = k_q + CW'(1);
        end else begin
          state_d = S_RUN;
          k_d     = k_q;
        end
      end
      S_DONE: begin
        done_s  = 1'b1;
        state_d = S_IDLE;
        k_d     = {CW{1'b0}};
      end
      default: begin
        state_d = S_IDLE;
        k_d     = {CW{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_online_mult_seq.sv
// Self-checking bench: two sequencer instances (8/3 and 2/3) driven in
// lockstep and compared every cycle against a transaction-level model.
module tb_online_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  online_mult_seq_if hs_a ();
  online_mult_seq_if hs_b ();

  logic       step_a, clr_a, inph_a, outph_a, last_a;
  logic [3:0] app_a, k_a;
  logic       step_b, clr_b, inph_b, outph_b, last_b;
  logic [2:0] app_b, k_b;

  online_mult_seq #(.N(8), .DELTA(3), .CW(4)) dut_a (
    .clk(clk), .rst(rst), .hs(hs_a),
    .step_en(step_a), .clr_w(clr_a), .app_idx(app_a), .k(k_a),
    .in_phase(inph_a), .out_phase(outph_a), .last(last_a)
  );

  online_mult_seq #(.N(2), .DELTA(3), .CW(3)) dut_b (
    .clk(clk), .rst(rst), .hs(hs_b),
    .step_en(step_b), .clr_w(clr_b), .app_idx(app_b), .k(k_b),
    .in_phase(inph_b), .out_phase(outph_b), .last(last_b)
  );

  int checks = 0;
  int errors = 0;

  // Model: state 0=idle 1=run 2=done, iteration index as a plain int.
  int m_n [2] = '{8, 2};
  int m_d [2] = '{3, 3};
  int m_st[2] = '{0, 0};
  int m_k [2] = '{0, 0};

  // Observed DUT activity, counted from the sampled outputs.
  int obs_in[2], obs_out[2], obs_step[2], obs_done[2], obs_done_cyc[2];
  int cyc;

  // Vector layout: busy done in_ready out_valid step clr inph outph last app[3:0] k[3:0]
  logic [16:0] exp_a, obs_a, exp_b, obs_b;
  localparam logic [16:0] RESET_VEC = 17'h00400;

  function automatic logic [16:0] model_vec(int d, bit iv, bit ordy, bit st);
    bit inph = (m_k[d] < m_n[d]);
    bit outph = (m_k[d] >= m_d[d]);
    bit lst = (m_k[d] == m_n[d] + m_d[d] - 1);
    bit run = (m_st[d] == 1);
    bit stp = run && (!inph || iv) && (!outph || ordy);
    bit ir = run && inph && (!outph || ordy);
    bit ov = run && outph && (!inph || iv);
    logic [3:0] kk = 4'(m_k[d]);
    return {m_st[d] != 0, m_st[d] == 2, ir, ov, stp, (m_st[d] == 0) && st,
            inph, outph, lst, inph ? kk : 4'd0, kk};
  endfunction

  task automatic model_edge(int d, logic [16:0] v);
    if (rst) begin
      m_st[d] = 0; m_k[d] = 0;
    end else begin
      case (m_st[d])
        0: if (v[11]) begin m_st[d] = 1; m_k[d] = 0; end
        1: if (v[12]) begin
             if (v[8]) begin m_st[d] = 2; m_k[d] = 0; end
             else m_k[d] = m_k[d] + 1;
           end
        default: begin m_st[d] = 0; m_k[d] = 0; end
      endcase
    end
  endtask

  task automatic clear_obs();
    for (int d = 0; d < 2; d++) begin
      obs_in[d] = 0; obs_out[d] = 0; obs_step[d] = 0; obs_done[d] = 0; obs_done_cyc[d] = -1;
    end
    cyc = 0;
  endtask

  // Drives one cycle from just after a falling edge and samples mid-cycle.
  task automatic drive_cycle(bit iv, bit ordy, bit st);
    hs_a.in_valid = iv; hs_a.out_ready = ordy; hs_a.start = st;
    hs_b.in_valid = iv; hs_b.out_ready = ordy; hs_b.start = st;
    #1;
    exp_a = model_vec(0, iv, ordy, st);
    exp_b = model_vec(1, iv, ordy, st);
    obs_a = {hs_a.busy, hs_a.done, hs_a.in_ready, hs_a.out_valid, step_a, clr_a,
             inph_a, outph_a, last_a, app_a, k_a};
    obs_b = {hs_b.busy, hs_b.done, hs_b.in_ready, hs_b.out_valid, step_b, clr_b,
             inph_b, outph_b, last_b, 1'b0, app_b, 1'b0, k_b};
    obs_in[0]   += int'(obs_a[14] & iv);   obs_in[1]   += int'(obs_b[14] & iv);
    obs_out[0]  += int'(obs_a[13] & ordy); obs_out[1]  += int'(obs_b[13] & ordy);
    obs_step[0] += int'(obs_a[12]);        obs_step[1] += int'(obs_b[12]);
    obs_done[0] += int'(obs_a[15]);        obs_done[1] += int'(obs_b[15]);
    if (obs_a[15] === 1'b1 && obs_done_cyc[0] < 0) obs_done_cyc[0] = cyc;
    if (obs_b[15] === 1'b1 && obs_done_cyc[1] < 0) obs_done_cyc[1] = cyc;
    @(posedge clk);
    model_edge(0, exp_a);
    model_edge(1, exp_b);
    cyc++;
    @(negedge clk);
  endtask

  task automatic settle();
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    hs_a.start = 1'b0; hs_a.in_valid = 1'b1; hs_a.out_ready = 1'b1;
    hs_b.start = 1'b0; hs_b.in_valid = 1'b1; hs_b.out_ready = 1'b1;
    @(negedge clk); #1;
    obs_a = {hs_a.busy, hs_a.done, hs_a.in_ready, hs_a.out_valid, step_a, clr_a,
             inph_a, outph_a, last_a, app_a, k_a};
    obs_b = {hs_b.busy, hs_b.done, hs_b.in_ready, hs_b.out_valid, step_b, clr_b,
             inph_b, outph_b, last_b, 1'b0, app_b, 1'b0, k_b};
    checks++;
    if (obs_a !== RESET_VEC) begin errors++; $display("FAIL reset_a got %h want %h", obs_a, RESET_VEC); end
    checks++;
    if (obs_b !== RESET_VEC) begin errors++; $display("FAIL reset_b got %h want %h", obs_b, RESET_VEC); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    clear_obs();
    for (int c = 0; c < 20; c++) begin
      drive_cycle(1'b1, 1'b1, c == 0);
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL basic_a cyc=%0d got %h want %h", c, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL basic_b cyc=%0d got %h want %h", c, obs_b, exp_b); end
      if (c == 0) begin
        checks++;
        if (obs_a[11] !== 1'b1) begin errors++; $display("FAIL basic_clr got %b want 1", obs_a[11]); end
      end
      if (c == 3) begin
        checks++;
        if (obs_b[14:12] !== 3'b001) begin
          errors++; $display("FAIL degen_idle_iter ir/ov/step got %b want 001", obs_b[14:12]);
        end
      end
      if (c == 13) begin
        checks++;
        if (obs_a[16] !== 1'b0) begin errors++; $display("FAIL basic_busy_low got %b want 0", obs_a[16]); end
      end
    end
    checks++;
    if (obs_done_cyc[0] != 12) begin errors++; $display("FAIL basic_done_cyc got %0d want 12", obs_done_cyc[0]); end
    checks++;
    if (obs_in[0] != 8 || obs_out[0] != 8 || obs_step[0] != 11) begin
      errors++; $display("FAIL basic_counts in=%0d out=%0d step=%0d want 8 8 11", obs_in[0], obs_out[0], obs_step[0]);
    end
    checks++;
    if (obs_done_cyc[1] != 6) begin errors++; $display("FAIL degen_done_cyc got %0d want 6", obs_done_cyc[1]); end
    checks++;
    if (obs_in[1] != 2 || obs_out[1] != 2 || obs_step[1] != 5) begin
      errors++; $display("FAIL degen_counts in=%0d out=%0d step=%0d want 2 2 5", obs_in[1], obs_out[1], obs_step[1]);
    end
  endtask

  task automatic test_input_stall();
    int stalls = 0;
    bit iv;
    clear_obs();
    for (int c = 0; c < 24; c++) begin
      iv = 1'b1;
      if (m_st[0] == 1 && m_k[0] == 5 && stalls < 2) begin iv = 1'b0; stalls++; end
      drive_cycle(iv, 1'b1, c == 0);
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL stall_a cyc=%0d got %h want %h", c, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL stall_b cyc=%0d got %h want %h", c, obs_b, exp_b); end
      if (!iv) begin
        checks++;
        if (obs_a[3:0] !== 4'd5 || obs_a[12] !== 1'b0 || obs_a[13] !== 1'b0) begin
          errors++; $display("FAIL stall_hold k=%0d step=%b ov=%b want 5 0 0", obs_a[3:0], obs_a[12], obs_a[13]);
        end
      end
    end
    checks++;
    if (obs_done_cyc[0] != 14) begin errors++; $display("FAIL stall_done_cyc got %0d want 14", obs_done_cyc[0]); end
  endtask

  task automatic test_backpressure();
    bit hit9 = 1'b0, hit4 = 1'b0, ordy;
    int which;
    clear_obs();
    for (int c = 0; c < 24; c++) begin
      ordy = 1'b1; which = 0;
      if (m_st[0] == 1 && m_k[0] == 9 && !hit9) begin ordy = 1'b0; hit9 = 1'b1; which = 9; end
      if (m_st[0] == 1 && m_k[0] == 4 && !hit4) begin ordy = 1'b0; hit4 = 1'b1; which = 4; end
      drive_cycle(1'b1, ordy, c == 0);
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL bp_a cyc=%0d got %h want %h", c, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL bp_b cyc=%0d got %h want %h", c, obs_b, exp_b); end
      if (which == 9) begin
        checks++;
        if (obs_a[14:12] !== 3'b010 || obs_a[3:0] !== 4'd9) begin
          errors++; $display("FAIL bp_flush ir/ov/step=%b k=%0d want 010 9", obs_a[14:12], obs_a[3:0]);
        end
      end
      if (which == 4) begin
        checks++;
        if (obs_a[14] !== 1'b0 || obs_a[12] !== 1'b0) begin
          errors++; $display("FAIL bp_steady in_ready=%b step=%b want 0 0", obs_a[14], obs_a[12]);
        end
      end
    end
    checks++;
    if (obs_done_cyc[0] != 14) begin errors++; $display("FAIL bp_done_cyc got %0d want 14", obs_done_cyc[0]); end
  endtask

  task automatic test_start_ignored();
    bit st, noise;
    clear_obs();
    for (int c = 0; c < 24; c++) begin
      noise = (m_st[0] == 1 && m_k[0] == 6) || (m_st[0] == 2);
      st = (c == 0) || noise;
      drive_cycle(1'b1, 1'b1, st);
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL ign_a cyc=%0d got %h want %h", c, obs_a, exp_a); end
      checks++;
      if (obs_b !== exp_b) begin errors++; $display("FAIL ign_b cyc=%0d got %h want %h", c, obs_b, exp_b); end
      if (noise) begin
        checks++;
        if (obs_a[11] !== 1'b0) begin errors++; $display("FAIL ign_clr got %b want 0", obs_a[11]); end
      end
    end
    checks++;
    if (obs_done[0] != 1 || obs_done_cyc[0] != 12) begin
      errors++; $display("FAIL ign_done count=%0d cyc=%0d want 1 12", obs_done[0], obs_done_cyc[0]);
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    for (int c = 0; c < 20 && !(m_st[0] == 1 && m_k[0] == 7); c++) drive_cycle(1'b1, 1'b1, c == 0);
    #2 rst = 1'b1;
    #1;
    obs_a = {hs_a.busy, hs_a.done, hs_a.in_ready, hs_a.out_valid, step_a, clr_a,
             inph_a, outph_a, last_a, app_a, k_a};
    checks++;
    if (obs_a !== RESET_VEC) begin errors++; $display("FAIL rst_mid_a got %h want %h", obs_a, RESET_VEC); end
    m_st[0] = 0; m_k[0] = 0; m_st[1] = 0; m_k[1] = 0;
    @(negedge clk);
    drive_cycle(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    clear_obs();
    for (int c = 0; c < 16; c++) begin
      drive_cycle(1'b1, 1'b1, c == 0);
      checks++;
      if (obs_a !== exp_a) begin errors++; $display("FAIL rst_rerun_a cyc=%0d got %h want %h", c, obs_a, exp_a); end
    end
    checks++;
    if (obs_step[0] != 11 || obs_done[0] != 1) begin
      errors++; $display("FAIL rst_rerun steps=%0d done=%0d want 11 1", obs_step[0], obs_done[0]);
    end
  endtask

  task automatic test_random();
    bit iv, ordy, st;
    for (int r = 0; r < 4; r++) begin
      settle();
      clear_obs();
      for (int c = 0; c < 400 && obs_done_cyc[0] < 0; c++) begin
        iv = 1'($urandom_range(0, 1));
        ordy = 1'($urandom_range(0, 1));
        st = (c == 0) || ($urandom_range(0, 7) == 0);
        drive_cycle(iv, ordy, st);
        checks++;
        if (obs_a !== exp_a) begin errors++; $display("FAIL rand_a run=%0d cyc=%0d got %h want %h", r, c, obs_a, exp_a); end
        checks++;
        if (obs_b !== exp_b) begin errors++; $display("FAIL rand_b run=%0d cyc=%0d got %h want %h", r, c, obs_b, exp_b); end
      end
      checks++;
      if (obs_done_cyc[0] < 0) begin errors++; $display("FAIL rand_timeout run=%0d got no done want done", r); end
      checks++;
      if (obs_in[0] != 8 || obs_out[0] != 8 || obs_step[0] != 11) begin
        errors++; $display("FAIL rand_counts run=%0d in=%0d out=%0d step=%0d want 8 8 11",
                           r, obs_in[0], obs_out[0], obs_step[0]);
      end
    end
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_basic();
    settle();
    test_input_stall();
    settle();
    test_backpressure();
    settle();
    test_start_ignored();
    settle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/online_mult_seq.md
Name: online_mult_seq

Overview:
- Iteration sequencer for the radix-2 MSD-first online multiplier datapath, i.e. the residual CSA, digit-append registers and output digit selection.
- Counts the N+DELTA online iterations of one multiplication and separates them into three phases: warm-up (input only), steady (input and output) and flush (output only).
- Drives the datapath step enable and the residual clear.
- Provides valid/ready handshakes on the serial input digit stream and the serial output digit stream.
- Holds no datapath state; it is a pure control block.

Parameters:
- N, 8: digits per operand and digits in the result (N >= 1).
- DELTA, 3: online delay in iterations (DELTA >= 1).
- CW, 4: iteration counter width; must satisfy 2^CW >= N+DELTA.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a multiplication; honoured only in IDLE.
- busy  output  1  high when state is not IDLE.
- done  output  1  one-cycle pulse after the last output digit is accepted.
- in_valid  input  1  source presents the digit pair x_j, y_j.
- in_ready  output  1  controller consumes the digit pair this cycle.
- out_valid  output  1  datapath output digit p_j is valid.
- out_ready  input  1  sink accepts p_j.
- step_en  output  1  datapath advances one iteration: append digits, load Ws/Wc, shift.
- clr_w  output  1  clears the Ws/Wc residual and the append registers.
- app_idx  output  CW  append position for the incoming digit; equals k while in_phase is high, 0 otherwise.
- k  output  CW  current iteration index, 0..N+DELTA-1.
- in_phase  output  1  high when k < N.
- out_phase  output  1  high when k >= DELTA.
- last  output  1  high when k == N+DELTA-1.

Behaviour:
- States: IDLE, RUN, DONE. State and k are registered.
- Reset values: state IDLE, k 0. With those, every output is 0, except in_phase, which decodes as 1 because k=0 < N.
  - Reset has effect at any time, including mid-operation.
  - After reset the datapath must be restarted with start; no partial result is produced.
- IDLE:
  - clr_w = start, combinational; the residual is cleared in the same cycle start is seen.
  - On start: go to RUN, k <= 0.
- RUN, iteration k:
  - need_in = in_phase; need_out = out_phase.
  - step_en = (!need_in | in_valid) & (!need_out | out_ready).
  - in_ready = need_in & (!need_out | out_ready).
  - out_valid = need_out & (!need_in | in_valid).
  - On step_en with !last: k <= k+1.
  - On step_en with last: go to DONE, k <= 0.
  - Without step_en: hold. No step, no append, no handshake completes on either side.
  - Input and output digits therefore transfer together in steady phase; a stall on either side stalls both.
  - Combinational paths in_valid -> out_valid and out_ready -> in_ready are intentional and must not be registered.
- DONE:
  - done = 1 for exactly one cycle, then go to IDLE. busy stays high during DONE.
  - start in DONE is ignored.
- start in RUN or DONE is ignored; it neither restarts nor queues.
- Handshake signals are forced to 0 in IDLE and DONE, whatever in_valid/out_ready do.
- Exact counts per multiplication:
  - N input transfers, N output transfers, N+DELTA step_en pulses.
  - Zero-stall latency from start to done is N+DELTA+1 cycles. Start is in cycle 0, RUN occupies cycles 1..N+DELTA, done is in cycle N+DELTA+1.
- If N <= DELTA, there are iterations with neither phase active. In those, step_en = 1 unconditionally and both handshakes are 0.
- k never exceeds N+DELTA-1; there is no wrap in RUN.

Test Plan:
- Basic run, N=8, DELTA=3, in_valid=1 and out_ready=1 throughout, start pulsed:
  - clr_w=1 in the start cycle.
  - in_ready high for k=0..7; out_valid high for k=3..10.
  - 11 step_en pulses; done in cycle 12; busy low in cycle 13.
- Input stall: in_valid=0 for 2 cycles at k=5 (steady phase) -> k holds at 5, step_en=0, out_valid=0 for those cycles, then the run resumes. done is 2 cycles later than in the basic run.
- Output backpressure:
  - out_ready=0 at k=9 (flush phase) -> k holds, out_valid=1, in_ready=0.
  - out_ready=0 at k=4 -> in_ready=0 despite in_valid=1.
- Start ignored: start pulsed at k=6 and in DONE -> no restart, no clr_w, exactly one done.
- Reset mid-run: rst asserted asynchronously at k=7, between clock edges -> outputs go low immediately, except in_phase, which reads 1 since k=0. State is IDLE, and a new start runs the full 11 iterations.
- Degenerate sizing, N=2, DELTA=3: k=2 has step_en=1 with in_ready=0 and out_valid=0. 5 steps in total, 2 input transfers and 2 output transfers.
